// File: rtl/lsu_mmio_ctrl.sv
// Load/store unit with a req/rsp handshake, byte/half/word access and memory-mapped board I/O.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses fault instead of being aligned down).
module lsu_mmio_ctrl #(
  parameter int DMEM_BYTES = 2048,
  parameter int NUM_HEX    = 8,
  parameter int SW_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [2:0]             funct3_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            st_data_i,
  input  logic [SW_WIDTH-1:0]    io_sw_i,
  output logic                   ready_o,
  output logic                   rsp_valid_o,
  output logic [31:0]            ld_data_o,
  output logic                   err_o,
  output logic [NUM_HEX*32-1:0]  io_hex_o,
  output logic [31:0]            io_ledr_o,
  output logic [31:0]            io_ledg_o,
  output logic [31:0]            io_lcd_o
);

  localparam int AW = $clog2(DMEM_BYTES / 4);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e                state_r, state_s;
  logic                  we_r;
  logic [2:0]            funct3_r;
  logic [11:0]           addr_r;
  logic [31:0]           data_r;
  logic [SW_WIDTH-1:0]   sw_meta_r, sw_sync_r;
  logic [31:0]           hex_r [NUM_HEX];
  logic [31:0]           ledr_r, ledg_r, lcd_r;
  logic [31:0]           mem [DMEM_BYTES/4];
  logic                  rsp_valid_r, err_r;
  logic [31:0]           ld_data_r;

  logic [11:0]           eff_addr_s;
  logic [9:0]            word_idx_s;
  logic [AW-1:0]         mem_idx_s;
  logic                  legal_s, misalign_s, is_mem_s, hex_hit_s, ledr_hit_s, ledg_hit_s, lcd_hit_s, sw_hit_s;
  logic                  err_s, reg_we_s, mem_we_s;
  logic [2:0]            hex_sel_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_s, rd_word_s, shifted_s, ld_s;
  logic                  unused_s;

  assign unused_s = ^addr_i[31:12];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return res;
  endfunction

  // Legality, alignment and address decode of the captured request.
  always_comb begin
    legal_s    = we_r ? (funct3_r inside {3'b000, 3'b001, 3'b010})
                      : (funct3_r inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    eff_addr_s = addr_r;
`ifdef LSU_MISALIGN_TRAP_EN
    if (funct3_r[1:0] == 2'b01) begin
      misalign_s = addr_r[0];
    end else if (funct3_r[1:0] == 2'b10) begin
      misalign_s = |addr_r[1:0];
    end else begin
      misalign_s = 1'b0;
    end
`else
    misalign_s = 1'b0;
    if (funct3_r[1:0] == 2'b01) begin
      eff_addr_s[0] = 1'b0;
    end else if (funct3_r[1:0] == 2'b10) begin
      eff_addr_s[1:0] = 2'b00;
    end else begin
      eff_addr_s = addr_r;
    end
`endif
    word_idx_s = eff_addr_s[11:2];
    mem_idx_s  = eff_addr_s[AW+1:2];
    is_mem_s   = (eff_addr_s < 12'(DMEM_BYTES));
    // HEXi lives at word 0x200 + 4*i, so i sits in word_idx[4:2].
    hex_hit_s  = (word_idx_s[9:5] == 5'b10000) && (word_idx_s[1:0] == 2'b00) &&
                 (32'(word_idx_s[4:2]) < NUM_HEX);
    hex_sel_s  = word_idx_s[4:2];
    ledr_hit_s = (word_idx_s == 10'h220);
    ledg_hit_s = (word_idx_s == 10'h224);
    lcd_hit_s  = (word_idx_s == 10'h228);
    sw_hit_s   = (word_idx_s == 10'h240);
    err_s      = !legal_s || misalign_s ||
                 !(is_mem_s || hex_hit_s || ledr_hit_s || ledg_hit_s || lcd_hit_s || sw_hit_s) ||
                 (we_r && sw_hit_s);
    reg_we_s   = (state_r == BUSY) && we_r && !err_s && !is_mem_s;
    mem_we_s   = (state_r == BUSY) && we_r && !err_s && is_mem_s;
  end

  // Store lane enables and lane-aligned store data.
  always_comb begin
    wdata_s = data_r << {eff_addr_s[1:0], 3'b000};
    case (funct3_r[1:0])
      2'b00:   be_s = 4'b0001 << eff_addr_s[1:0];
      2'b01:   be_s = 4'b0011 << eff_addr_s[1:0];
      2'b10:   be_s = 4'b1111;
      default: be_s = 4'b0000;
    endcase
  end

  // Read word selection, lane shift and sign/zero extension.
  always_comb begin
    if (is_mem_s) begin
      rd_word_s = mem[mem_idx_s];
    end else if (hex_hit_s) begin
      rd_word_s = hex_r[hex_sel_s];
    end else if (ledr_hit_s) begin
      rd_word_s = ledr_r;
    end else if (ledg_hit_s) begin
      rd_word_s = ledg_r;
    end else if (lcd_hit_s) begin
      rd_word_s = lcd_r;
    end else if (sw_hit_s) begin
      rd_word_s = 32'(sw_sync_r);
    end else begin
      rd_word_s = 32'h0000_0000;
    end
    shifted_s = rd_word_s >> {eff_addr_s[1:0], 3'b000};
    case (funct3_r)
      3'b000:  ld_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  ld_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  ld_s = shifted_s;
      3'b100:  ld_s = {24'h000000, shifted_s[7:0]};
      3'b101:  ld_s = {16'h0000, shifted_s[15:0]};
      default: ld_s = 32'h0000_0000;
    endcase
    if (we_r || err_s) begin
      ld_s = 32'h0000_0000;
    end else begin
      ld_s = ld_s;
    end
  end

  // Next-state logic: IDLE -> BUSY -> RESP -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = req_i ? BUSY : IDLE;
      BUSY:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Request capture on acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= 12'h000;
      data_r   <= 32'h0000_0000;
    end else if (state_r == IDLE && req_i) begin
      we_r     <= we_i;
      funct3_r <= funct3_i;
      addr_r   <= addr_i[11:0];
      data_r   <= st_data_i;
    end
  end

  // Switch synchroniser.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta_r <= '0;
      sw_sync_r <= '0;
    end else begin
      sw_meta_r <= io_sw_i;
      sw_sync_r <= sw_meta_r;
    end
  end

  // Response registers, loaded at the end of BUSY.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r <= 1'b0;
      err_r       <= 1'b0;
      ld_data_r   <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= (state_r == BUSY);
      if (state_r == BUSY) begin
        err_r     <= err_s;
        ld_data_r <= ld_s;
      end
    end
  end

  // Peripheral registers with byte-lane writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_HEX; i++) hex_r[i] <= 32'h0000_0000;
      ledr_r <= 32'h0000_0000;
      ledg_r <= 32'h0000_0000;
      lcd_r  <= 32'h0000_0000;
    end else if (reg_we_s) begin
      if (hex_hit_s)  hex_r[hex_sel_s] <= merge_lanes(hex_r[hex_sel_s], wdata_s, be_s);
      if (ledr_hit_s) ledr_r <= merge_lanes(ledr_r, wdata_s, be_s);
      if (ledg_hit_s) ledg_r <= merge_lanes(ledg_r, wdata_s, be_s);
      if (lcd_hit_s)  lcd_r  <= merge_lanes(lcd_r, wdata_s, be_s);
    end
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) mem[mem_idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    assign io_hex_o[32*g +: 32] = hex_r[g];
  end

  assign ready_o     = (state_r == IDLE);
  assign rsp_valid_o = rsp_valid_r;
  assign ld_data_o   = ld_data_r;
  assign err_o       = err_r;
  assign io_ledr_o   = ledr_r;
  assign io_ledg_o   = ledg_r;
  assign io_lcd_o    = lcd_r;

endmodule

// File: tb/tb_lsu_mmio_ctrl.sv
// Randomised bench for lsu_mmio_ctrl against a byte-addressed reference model of the address map.
module tb_lsu_mmio_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [2:0]   f3 = 3'b000;
  logic [31:0]  addr = 32'h0;
  logic [31:0]  st_data = 32'h0;
  logic [31:0]  sw = 32'h0;
  logic         ready, rsp_valid, err;
  logic [31:0]  ld_data, ledr, ledg, lcd;
  logic [255:0] hex;

  int          n_total = 0;
  int          n_bad = 0;
  logic [7:0]  byte_m [4096];
  logic [31:0] sw_cur = 32'h0;

  lsu_mmio_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .funct3_i(f3), .addr_i(addr),
    .st_data_i(st_data), .io_sw_i(sw), .ready_o(ready), .rsp_valid_o(rsp_valid),
    .ld_data_o(ld_data), .err_o(err), .io_hex_o(hex), .io_ledr_o(ledr), .io_ledg_o(ledg),
    .io_lcd_o(lcd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {byte_m[a+3], byte_m[a+2], byte_m[a+1], byte_m[a]};
  endfunction

  function automatic bit is_reg_word(input int wa);
    for (int i = 0; i < 8; i++) if (wa == 'h800 + 16*i) return 1'b1;
    return (wa == 'h880) || (wa == 'h890) || (wa == 'h8A0);
  endfunction

  // Reference: the map is a flat byte space; a legal access touches n consecutive bytes.
  task automatic model_access(input bit w, input logic [2:0] f, input logic [11:0] a0, input logic [31:0] d,
                              output logic [31:0] exp_d, output logic exp_e);
    int n, a, wa;
    bit legal, mis, issw, mapped;
    logic [31:0] v;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << f[1:0];
    a = int'(a0);
    mis = (a % n) != 0;
`ifndef LSU_MISALIGN_TRAP_EN
    a = a - (a % n);
    mis = 1'b0;
`endif
    wa = a - (a % 4);
    issw = (wa == 'h900);
    mapped = (a < 2048) || is_reg_word(wa) || issw;
    exp_e = !legal || mis || !mapped || (w && issw);
    exp_d = 32'h0;
    v = 32'h0;
    if (!exp_e && w) begin
      for (int k = 0; k < n; k++) byte_m[a+k] = d[8*k +: 8];
    end else if (!exp_e) begin
      for (int k = 0; k < n; k++) v[8*k +: 8] = issw ? sw_cur[8*(a-wa+k) +: 8] : byte_m[a+k];
      if (!f[2] && n < 4 && v[8*n-1]) begin
        for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      end
      exp_d = v;
    end
  endtask

  task automatic check_periph(input string tag);
    for (int i = 0; i < 8; i++) check_val({tag, "_hex"}, hex[32*i +: 32], model_word('h800 + 16*i));
    check_val({tag, "_ledr"}, ledr, model_word('h880));
    check_val({tag, "_ledg"}, ledg, model_word('h890));
    check_val({tag, "_lcd"}, lcd, model_word('h8A0));
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends RESP.
  task automatic do_access(input bit w, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] d,
                           input string tag);
    logic [31:0] ed;
    logic        ee;
    int          guard = 0;
    while (!ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val({tag, "_ready"}, {31'b0, ready}, 32'd1);
    model_access(w, f, ad[11:0], d, ed, ee);
    req = 1'b1; we = w; f3 = f; addr = ad; st_data = d;
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom; st_data = $urandom;
    check_val({tag, "_rsp_early"}, {31'b0, rsp_valid}, 32'd0);
    check_val({tag, "_busy_rdy"}, {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check_val({tag, "_ld_data"}, ld_data, ed);
    check_val({tag, "_err"}, {31'b0, err}, {31'b0, ee});
    check_periph(tag);
    @(posedge clk); #1;
    check_val({tag, "_rsp_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int sel, idx, a;
    logic [31:0] tmp;
    for (int i = 0; i < 4096; i++) byte_m[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_ready", {31'b0, ready}, 32'd1);
    check_val("rst_rsp", {31'b0, rsp_valid}, 32'd0);
    check_val("rst_ld", ld_data, 32'd0);
    check_val("rst_err", {31'b0, err}, 32'd0);
    check_periph("rst");

    for (int i = 0; i < 64; i++) do_access(1'b1, 3'b010, 32'(4*i), $urandom, "init");

    do_access(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, "sw_010");
    do_access(1'b0, 3'b010, 32'h010, 32'h0, "lw_010");
    do_access(1'b1, 3'b000, 32'h013, 32'h80, "sb_013");
    do_access(1'b0, 3'b000, 32'h013, 32'h0, "lb_013");
    do_access(1'b0, 3'b100, 32'h013, 32'h0, "lbu_013");
    do_access(1'b0, 3'b010, 32'h010, 32'h0, "lw_010b");
    do_access(1'b1, 3'b001, 32'h802, 32'h1234, "sh_hex0");
    do_access(1'b1, 3'b010, 32'h880, 32'h5, "sw_ledr");
    sw = 32'hA5; sw_cur = 32'hA5;
    repeat (3) @(posedge clk);
    #1;
    do_access(1'b0, 3'b101, 32'h900, 32'h0, "lhu_sw");
    do_access(1'b1, 3'b010, 32'h900, 32'h77, "st_sw");
    do_access(1'b0, 3'b010, 32'h011, 32'h0, "lw_011");
    do_access(1'b1, 3'b011, 32'h020, 32'h1, "illegal_st");
    do_access(1'b0, 3'b110, 32'h020, 32'h0, "illegal_ld");
    do_access(1'b1, 3'b010, 32'h8B0, 32'h1, "unmapped_st");
    do_access(1'b0, 3'b010, 32'h7FC, 32'h0, "mem_top_ld");

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(99) < 5) begin
        sw = $urandom; sw_cur = sw;
        repeat (3) @(posedge clk);
        #1;
      end
      sel = $urandom_range(99);
      if (sel < 55) begin
        a = $urandom_range(255);
      end else if (sel < 80) begin
        idx = $urandom_range(10);
        a = (idx < 8) ? ('h800 + 16*idx) : ('h880 + 16*(idx-8));
        a = a + $urandom_range(3);
      end else if (sel < 90) begin
        a = 'h900 + $urandom_range(3);
      end else begin
        a = 'h800 + $urandom_range(2047);
      end
      tmp = $urandom;
      do_access(1'($urandom_range(1)), 3'($urandom_range(7)), {tmp[31:12], 12'(a)}, $urandom, "rnd");
    end

    // Reset while a LEDG store sits in BUSY: the store must vanish.
    req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h890; st_data = 32'h1;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("arst_ready", {31'b0, ready}, 32'd1);
    for (int i = 'h800; i < 'h8B0; i++) byte_m[i] = 8'h00;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_val("arst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    check_val("arst_ready2", {31'b0, ready}, 32'd1);
    check_periph("arst");
    do_access(1'b0, 3'b010, 32'h010, 32'h0, "post_rst_lw");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
